// File: rtl/sample_output_i2s.sv
// I2S output stage for the voice mixer: master-volume gain, scale/saturate to
// 16 bits, a one-deep pending buffer, and a 64-BCLK mono-duplicated frame.
module sample_output_i2s #(
  parameter int BCLK_DIV = 8,
  parameter int SHIFT    = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic signed [23:0] i_sample,
  input  logic               i_sample_valid,
  input  logic [7:0]         i_volume,
  output logic               o_bclk,
  output logic               o_lrclk,
  output logic               o_sdata,
  output logic               o_underrun,
  output logic               o_overrun
);

  localparam int               DIV_W    = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam int               SCALE_SH = 8 + SHIFT;

  // Gain stage
  logic signed [32:0] sample_ext;
  logic signed [32:0] gain_ext;
  logic signed [32:0] prod_d, prod_q;
  logic               prod_vld_d, prod_vld_q;

  // Scale stage
  logic signed [32:0] shifted;
  logic [15:0]        scaled;
  logic               pend_wr;

  // Pending buffer and frame
  logic [15:0]        pend_d, pend_q;
  logic               full_d, full_q;
  logic [15:0]        frame_d, frame_q;
  logic               underrun_d, underrun_q;
  logic               overrun_d, overrun_q;

  // Bit clock and serializer
  logic [DIV_W-1:0]   div_cnt_d, div_cnt_q;
  logic               bclk_d, bclk_q;
  logic               div_wrap;
  logic               bclk_fall;
  logic               frame_load;
  logic [5:0]         bit_cnt_d, bit_cnt_q;
  logic [4:0]         slot_pos;
  logic               lrclk_d, lrclk_q;
  logic               sdata_d, sdata_q;

  // Volume is captured together with the sample; gain = (vol+1)/256.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    sample_ext = {{9{i_sample[23]}}, i_sample};
    gain_ext   = {24'd0, {1'b0, i_volume} + 9'd1};
    prod_vld_d = i_sample_valid;
    prod_d     = prod_q;
    if (i_sample_valid) begin
      prod_d = sample_ext * gain_ext;
    end
  end

  always_comb begin
    shifted = prod_q >>> SCALE_SH;
    pend_wr = prod_vld_q;
    if (shifted > 33'sd32767) begin
      scaled = 16'h7FFF;
    end else if (shifted < -33'sd32768) begin
      scaled = 16'h8000;
    end else begin
      scaled = shifted[15:0];
    end
  end

  // BCLK toggles on every divider wrap; the frame advances on its falling edge.
  always_comb begin
    div_wrap   = (div_cnt_q == DIV_LAST);
    div_cnt_d  = div_wrap ? '0 : div_cnt_q + 1'b1;
    bclk_d     = div_wrap ? ~bclk_q : bclk_q;
    bclk_fall  = div_wrap & bclk_q;
    frame_load = bclk_fall & (bit_cnt_q == 6'd63);
    bit_cnt_d  = bclk_fall ? bit_cnt_q + 6'd1 : bit_cnt_q;
  end

  always_comb begin
    pend_d     = pend_q;
    full_d     = full_q;
    frame_d    = frame_q;
    underrun_d = 1'b0;
    overrun_d  = 1'b0;
    if (frame_load) begin
      if (full_q) begin
        // Older pending goes out first; a coincident write refills the buffer.
        frame_d = pend_q;
        if (pend_wr) begin
          pend_d = scaled;
        end else begin
          full_d = 1'b0;
        end
      end else if (pend_wr) begin
        frame_d = scaled;
      end else begin
        underrun_d = 1'b1;
      end
    end else if (pend_wr) begin
      pend_d    = scaled;
      full_d    = 1'b1;
      overrun_d = full_q;
    end
  end

  // Both slots carry the same word: position 1..16 within a half-frame is MSB..LSB.
  always_comb begin
    slot_pos = bit_cnt_d[4:0];
    lrclk_d  = lrclk_q;
    sdata_d  = sdata_q;
    if (bclk_fall) begin
      lrclk_d = bit_cnt_d[5];
      if ((slot_pos != 5'd0) && (slot_pos <= 5'd16)) begin
        sdata_d = frame_q[4'(5'd16 - slot_pos)];
      end else begin
        sdata_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      pend_q     <= '0;
      full_q     <= 1'b0;
      frame_q    <= '0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      bit_cnt_q  <= '0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
    end else begin
      // NOTE: state updates use <= so every flop samples pre-edge values regardless of order.
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      pend_q     <= pend_d;
      full_q     <= full_d;
      frame_q    <= frame_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      bit_cnt_q  <= bit_cnt_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
    end
  end

  assign o_bclk     = bclk_q;
  assign o_lrclk    = lrclk_q;
  assign o_sdata    = sdata_q;
  assign o_underrun = underrun_q;
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_sample_output_i2s.sv
// Bench for sample_output_i2s: SHIFT=8 and SHIFT=4 instances share stimulus; an
// I2S receiver decodes both outputs and compares each frame against a queue.
module tb_sample_output_i2s;

  localparam int FR = 1024;

  typedef struct packed {
    logic [15:0] w8;
    logic [15:0] w4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] sample;
  logic        valid;
  logic [7:0]  vol;
  logic [1:0]  bclk, lrclk, sdata, underrun, overrun;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc;
  exp_t sb_q[$];

  int          mon_cnt;
  logic        mon_lr_prev, mon_bclk_prev;
  logic [15:0] word [2];
  logic [15:0] left [2];
  int          pad [2];
  int          ur_cnt [2];
  int          ov_cnt [2];
  exp_t        mon_e;

  sample_output_i2s #(.BCLK_DIV(8), .SHIFT(8)) u_dut8 (
    .i_clk(clk), .i_reset(rst), .i_sample(sample), .i_sample_valid(valid),
    .i_volume(vol), .o_bclk(bclk[0]), .o_lrclk(lrclk[0]), .o_sdata(sdata[0]),
    .o_underrun(underrun[0]), .o_overrun(overrun[0])
  );

  sample_output_i2s #(.BCLK_DIV(8), .SHIFT(4)) u_dut4 (
    .i_clk(clk), .i_reset(rst), .i_sample(sample), .i_sample_valid(valid),
    .i_volume(vol), .o_bclk(bclk[1]), .o_lrclk(lrclk[1]), .o_sdata(sdata[1]),
    .o_underrun(underrun[1]), .o_overrun(overrun[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [15:0] w8, input logic [15:0] w4);
    exp_t e;
    e.w8 = w8;
    e.w4 = w4;
    sb_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Valid is sampled on the edge that brings cyc to 'at'.
  task automatic strobe(input int at, input logic [23:0] s, input logic [7:0] v);
    wait_cyc(at - 1);
    sample = s;
    vol    = v;
    valid  = 1'b1;
    @(negedge clk);
    valid  = 1'b0;
    sample = 24'h5A5A5A;
    vol    = 8'h00;
  endtask

  task automatic check_pulses(input string tag, input int ur, input int ov);
    check({tag, "_ur8"}, ur_cnt[0], ur);
    check({tag, "_ur4"}, ur_cnt[1], ur);
    check({tag, "_ov8"}, ov_cnt[0], ov);
    check({tag, "_ov4"}, ov_cnt[1], ov);
  endtask

  // I2S receiver: data is stable at BCLK rise; slot bit 1..16 follows each LRCLK edge.
  always @(negedge clk) begin
    if (rst) begin
      mon_cnt       = -1;
      mon_lr_prev   = 1'b0;
      mon_bclk_prev = 1'b0;
      for (int d = 0; d < 2; d++) begin
        word[d]   = '0;
        left[d]   = '0;
        pad[d]    = 0;
        ur_cnt[d] = 0;
        ov_cnt[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        ur_cnt[d] += int'(underrun[d]);
        ov_cnt[d] += int'(overrun[d]);
      end
      if (bclk[0] && !mon_bclk_prev) begin
        if (lrclk[0] != mon_lr_prev) mon_cnt = 0;
        else                         mon_cnt++;
        mon_lr_prev = lrclk[0];
        for (int d = 0; d < 2; d++) begin
          if (mon_cnt >= 1 && mon_cnt <= 16) word[d] = {word[d][14:0], sdata[d]};
          else if (sdata[d])                 pad[d]++;
        end
        if (mon_cnt == 16 && !lrclk[0]) begin
          left[0] = word[0];
          left[1] = word[1];
        end
        if (mon_cnt == 16 && lrclk[0]) begin
          check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check("left_s8", left[0], mon_e.w8);
            check("right_s8", word[0], mon_e.w8);
            check("left_s4", left[1], mon_e.w4);
            check("right_s4", word[1], mon_e.w4);
          end
          check("pad_s8", pad[0], 0);
          check("pad_s4", pad[1], 0);
          pad[0] = 0;
          pad[1] = 0;
        end
      end
      mon_bclk_prev = bclk[0];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    valid  = 1'b0;
    sample = '0;
    vol    = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {bclk, lrclk, sdata, underrun, overrun}, 10'd0);
    rst = 1'b0;

    // Idle frames: clock timing, zero data, one underrun per boundary.
    push_exp(16'h0000, 16'h0000);
    wait_cyc(7);    check("bclk_c7", bclk, 2'b00);
    wait_cyc(8);    check("bclk_c8", bclk, 2'b11);
    wait_cyc(15);   check("bclk_c15", bclk, 2'b11);
    wait_cyc(16);   check("bclk_c16", bclk, 2'b00);
    wait_cyc(24);   check("bclk_c24", bclk, 2'b11);
    wait_cyc(511);  check("lr_c511", lrclk, 2'b00);
    wait_cyc(512);  check("lr_c512", lrclk, 2'b11);
    wait_cyc(1023); check("lr_c1023", lrclk, 2'b11);
    wait_cyc(1024); check("lr_c1024", lrclk, 2'b00);
    push_exp(16'h0000, 16'h0000);
    wait_cyc(FR + 10);
    check_pulses("l1", 1, 0);

    // Gain, scale and saturation patterns, one per frame.
    strobe(FR + 500, 24'h123400, 8'hFF);     push_exp(16'h1234, 16'h7FFF);
    wait_cyc(2 * FR + 10);
    check_pulses("l2", 1, 0);
    strobe(2 * FR + 500, 24'h800000, 8'hFF); push_exp(16'h8000, 16'h8000);
    strobe(3 * FR + 500, 24'h123400, 8'd127); push_exp(16'h091A, 16'h7FFF);
    strobe(4 * FR + 500, 24'hFF0000, 8'hFF); push_exp(16'hFF00, 16'hF000);
    strobe(5 * FR + 500, 24'h7FFFFF, 8'h00); push_exp(16'h007F, 16'h07FF);

    // Overwrite of an unsent pending sample.
    strobe(6 * FR + 300, 24'h010000, 8'hFF);
    wait_cyc(6 * FR + 310);
    check_pulses("ow_first", 1, 0);
    strobe(6 * FR + 600, 24'h020000, 8'hFF); push_exp(16'h0200, 16'h2000);
    wait_cyc(6 * FR + 610);
    check_pulses("ow_second", 1, 1);

    // Starved frame repeats the previous word.
    wait_cyc(7 * FR + 800);                  push_exp(16'h0200, 16'h2000);
    wait_cyc(8 * FR + 10);
    check_pulses("l8", 2, 1);

    // Pending write on the load cycle, flag clear: bypass into the frame.
    strobe(9 * FR - 1, 24'h030000, 8'hFF);   push_exp(16'h0300, 16'h3000);
    wait_cyc(9 * FR + 10);
    check_pulses("l9", 2, 1);

    // Pending write on the load cycle, flag set: older goes first.
    strobe(9 * FR + 300, 24'h040000, 8'hFF); push_exp(16'h0400, 16'h4000);
    strobe(10 * FR - 1, 24'h050000, 8'hFF);  push_exp(16'h0500, 16'h5000);
    wait_cyc(10 * FR + 10);
    check_pulses("l10", 2, 1);
    wait_cyc(11 * FR + 10);
    check_pulses("l11", 2, 1);
    wait_cyc(12 * FR + 10);
    check_pulses("l12", 3, 1);

    // Mid-frame reset at bit_cnt=20 with a pending and an in-flight sample.
    strobe(12 * FR + 100, 24'h060000, 8'hFF);
    strobe(12 * FR + 329, 24'h070000, 8'hFF);
    check("pre_rst_bclk", bclk, 2'b11);
    check("pre_rst_sb_empty", sb_q.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_outputs", {bclk, lrclk, sdata, underrun, overrun}, 10'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    push_exp(16'h0000, 16'h0000);
    wait_cyc(7);  check("rel_bclk_c7", bclk, 2'b00);
    wait_cyc(8);  check("rel_bclk_c8", bclk, 2'b11);
    push_exp(16'h0000, 16'h0000);
    wait_cyc(FR + 10);
    check_pulses("rel_l1", 1, 0);
    wait_cyc(FR + 800);
    check("final_sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
